// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the initiator FSM state type.
// Used by the initiators and by the word-addressed AHB slaves.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } ahb_state_t;

endpackage

// File: rtl/ahb_wait_timer.sv
// Data-phase wait counter: cleared at the address phase, counts stalled cycles and
// saturates at LIMIT. LIMIT=0 disables expiry so the initiator waits forever.
module ahb_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int         W       = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);
    localparam bit         ENABLED = (LIMIT > 0);

    logic [W-1:0] r_count;
    logic         w_at_limit;

    assign w_at_limit = (r_count == LIMIT_V);
    assign o_expired  = ENABLED && w_at_limit;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/ahb_master.sv
// Single-outstanding AHB-Lite initiator: one valid/ready command becomes one NONSEQ
// word transfer (address phase, then data phase) and yields exactly one response pulse.
module ahb_master
    import ahb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        HTRANS,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY
);

    ahb_state_t        r_state;
    ahb_state_t        w_next;
    logic [DATA_W-1:0] r_wdata;
    logic              w_accept;
    logic              w_aligned;
    logic              w_expired;

    assign w_accept  = cmd_valid && cmd_ready;
    assign w_aligned = (cmd_addr[1:0] == 2'b00);

    ahb_wait_timer #(
        .LIMIT (TIMEOUT)
    ) u_wait_timer (
        .i_clk     (HCLK),
        .i_rst     (HRESET),
        .i_clear   (r_state == ST_ADDR),
        .i_enable  ((r_state == ST_DATA) && !HREADY),
        .o_expired (w_expired)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && w_aligned) w_next = ST_ADDR;
            ST_ADDR: w_next = ST_DATA;
            ST_DATA: if (w_expired || HREADY) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == ST_IDLE);
        HTRANS    = (r_state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        HSIZE     = HSIZE_WORD;
    end

    // Expiry wins over HREADY in the same cycle, so a late slave cannot complete an aborted phase.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            HADDR     <= '0;
            HWRITE    <= 1'b0;
            HWDATA    <= '0;
            r_wdata   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (w_accept) begin
                if (w_aligned) begin
                    HADDR   <= cmd_addr;
                    HWRITE  <= cmd_write;
                    r_wdata <= cmd_wdata;
                end else begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                end
            end
            if (r_state == ST_ADDR) begin
                HWDATA <= r_wdata;
            end
            if (r_state == ST_DATA) begin
                if (w_expired) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                end else if (HREADY) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= HWRITE ? '0 : HRDATA;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_master.sv
// Randomized scoreboard bench for ahb_master with a word-addressed memory slave model.
module tb_ahb_master;
    import ahb_pkg::*;

    localparam int TO = 4;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  HTRANS;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA = '0;
    logic        HREADY = 1'b1;

    ahb_master #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .HTRANS    (HTRANS),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        int          waits;
    } bus_t;

    rsp_t        sq[$];
    bus_t        bq[$];
    logic [31:0] ref_mem[16];
    logic [31:0] bus_mem[16];
    int          n_checks = 0;
    int          n_pass = 0;

    bit          s_active = 0;
    int          s_left = 0;
    bit          s_to = 0;
    bus_t        s_cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Called just after a rising edge; returns one cycle after acceptance.
    task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                         input int w, input bit track, output int t_acc);
        int   n;
        int   idx;
        rsp_t r;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        n = 0;
        t_acc = -1;
        forever begin
            @(negedge HCLK);
            if (cmd_ready) break;
            n++;
            if (n > 60) begin
                chk("cmd_ready_wait", 32'd0, 32'd1);
                cmd_valid = 1'b0;
                return;
            end
        end
        t_acc = cyc;
        idx = int'(addr[5:2]);
        if (addr[1:0] != 2'b00) begin
            r = '{cyc: t_acc + 1, rdata: 32'd0, err: 1'b1};
            if (track) sq.push_back(r);
        end else begin
            bq.push_back('{cyc: t_acc + 1, addr: addr, wdata: wd, wr: wr, waits: w});
            if (w >= TO) begin
                r = '{cyc: t_acc + 3 + TO, rdata: 32'd0, err: 1'b1};
            end else begin
                if (wr && track) ref_mem[idx] = wd;
                r = '{cyc: t_acc + 3 + w, rdata: wr ? 32'd0 : ref_mem[idx], err: 1'b0};
            end
            if (track) sq.push_back(r);
        end
        @(posedge HCLK);
        #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge HCLK);
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        int          t;
        int          w;
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;

        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 32'd0;
            bus_mem[i] = 32'd0;
        end

        fork
            forever begin
                @(negedge HCLK);
                // response monitor
                if (rsp_valid) begin
                    if (sq.size() == 0) begin
                        chk("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        rsp_t e;
                        e = sq.pop_front();
                        chk("rsp_cycle", cyc, e.cyc);
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    end
                end
                // memory slave, sets HREADY/HRDATA for the coming edge
                if (HRESET) begin
                    s_active = 0;
                    HREADY   = 1'b1;
                end else if (HTRANS == HTRANS_NONSEQ) begin
                    if (bq.size() == 0) begin
                        chk("unexpected_nonseq", 32'd1, 32'd0);
                        s_active = 0;
                    end else begin
                        s_cur = bq.pop_front();
                        chk("addr_phase_cycle", cyc, s_cur.cyc);
                        chk("haddr", HADDR, s_cur.addr);
                        chk("hwrite", 32'(HWRITE), 32'(s_cur.wr));
                        chk("hsize", 32'(HSIZE), 32'(HSIZE_WORD));
                        s_left   = s_cur.waits;
                        s_to     = (s_cur.waits >= TO);
                        s_active = 1;
                    end
                    HREADY = 1'($urandom_range(0, 1));
                    HRDATA = $urandom;
                end else if (s_active) begin
                    if (s_left > 0) begin
                        HREADY = 1'b0;
                        HRDATA = $urandom;
                        s_left--;
                    end else begin
                        HREADY   = 1'b1;
                        s_active = 0;
                        if (s_to) begin
                            HRDATA = $urandom;
                        end else if (s_cur.wr) begin
                            chk("hwdata", HWDATA, s_cur.wdata);
                            bus_mem[s_cur.addr[5:2]] = HWDATA;
                            HRDATA = $urandom;
                        end else begin
                            HRDATA = bus_mem[s_cur.addr[5:2]];
                        end
                    end
                end else begin
                    HREADY = 1'($urandom_range(0, 1));
                    HRDATA = $urandom;
                end
            end
        join_none

        repeat (3) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("reset_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
        chk("reset_haddr", HADDR, 32'd0);
        chk("reset_hwrite", 32'(HWRITE), 32'd0);
        chk("reset_hwdata", HWDATA, 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge HCLK);
        #1;

        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b1, t);
        idle_cycles(2);
        issue(1'b0, 32'h0000_0010, 32'h0, 3, 1'b1, t);
        idle_cycles(6);
        issue(1'b0, 32'h0000_0010, 32'h0, TO, 1'b1, t);
        idle_cycles(TO + 6);
        issue(1'b1, 32'h0000_0014, 32'h1234_5678, TO + 2, 1'b1, t);
        idle_cycles(TO + 8);
        issue(1'b1, 32'h0000_0012, 32'hCAFE_F00D, 0, 1'b1, t);
        idle_cycles(2);
        issue(1'b1, 32'h0000_0020, 32'hA5A5_0F0F, 0, 1'b1, t);
        issue(1'b0, 32'h0000_0020, 32'h0, 0, 1'b1, t);
        issue(1'b0, 32'h0000_0014, 32'h0, 1, 1'b1, t);

        for (int k = 0; k < 150; k++) begin
            wr = 1'($urandom);
            a  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            d  = $urandom;
            w  = ($urandom_range(0, 7) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, 3);
            issue(wr, a, d, w, 1'b1, t);
            if (w >= TO && a[1:0] == 2'b00) idle_cycles(TO + 6);
            else if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(0, 3));
        end
        idle_cycles(TO + 8);

        // reset while the data phase is stalled: the transfer must vanish without a response
        issue(1'b0, 32'h0000_0008, 32'h0, 3, 1'b0, t);
        @(negedge HCLK);
        HRESET = 1'b1;
        @(negedge HCLK);
        chk("rst_mid_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("rst_release_cmd_ready", 32'(cmd_ready), 32'd1);
        idle_cycles(8);
        issue(1'b0, 32'h0000_0020, 32'h0, 2, 1'b1, t);

        for (int n = 0; n < 300; n++) begin
            if (sq.size() == 0 && bq.size() == 0) break;
            @(negedge HCLK);
        end
        chk("drain_rsp_queue", 32'(sq.size()), 32'd0);
        chk("drain_bus_queue", 32'(bq.size()), 32'd0);
        repeat (TO + 6) @(negedge HCLK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
